// File: rtl/fb_paint_responder.sv
// fb_paint_responder: framebuffer-side responder for the paint/cursor write port.
// Paint writes are queued in a small FIFO and retire into the single-port
// 64x64x8 framebuffer RAM in cycles the display scan does not claim.
// Optional build macro: FB_STARVE_GUARD_EN adds a starvation counter that forces
// one queued write after STARVE_LIMIT consecutive blocked cycles.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no read, FIFO empty; RAM address and write data hold
// ST_READ  | scan read granted; RAM addressed by rd_addr
// ST_WRITE | FIFO head written to RAM and popped
// ST_FORCE | (guard build only) head written while the scan is stalled
module fb_paint_responder #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        paint,
    input  logic [5:0]  in_x,
    input  logic [5:0]  in_y,
    input  logic [7:0]  px_data,
    output logic        busy,
    output logic        overflow,
    input  logic        rd_en,
    input  logic [11:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [7:0]  rd_data,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
`ifdef FB_STARVE_GUARD_EN
    localparam logic [1:0] ST_FORCE = 2'd3;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
`endif

    // Entry layout: {y[5:0], x[5:0], data[7:0]}; the top 12 bits are the RAM address.
    logic [19:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [19:0]   head;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [1:0]    state;
    logic [11:0]   last_addr;
    logic [7:0]    last_wdata;

`ifdef FB_STARVE_GUARD_EN
    logic [SW-1:0] starve_cnt;
    logic          force_wr;
    assign force_wr = !fifo_empty && (starve_cnt == SW'(STARVE_LIMIT));
`endif

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);

    // Per-cycle arbitration: a forced write beats the scan, the scan beats normal writes.
    always_comb begin
        state = ST_IDLE;
`ifdef FB_STARVE_GUARD_EN
        if (force_wr)
            state = ST_FORCE;
        else
`endif
        if (rd_en)
            state = ST_READ;
        else if (!fifo_empty)
            state = ST_WRITE;
    end

`ifdef FB_STARVE_GUARD_EN
    assign pop = !rst && ((state == ST_WRITE) || (state == ST_FORCE));
`else
    assign pop = !rst && (state == ST_WRITE);
`endif
    // Full check uses the pre-pop count, so a paint on a full FIFO is dropped.
    assign push = !rst && paint && (count != FULL_CNT);

    assign rd_ready  = (state == ST_READ);
    assign mem_we    = pop;
    assign mem_addr  = rd_ready ? rd_addr : (pop ? head[19:8] : last_addr);
    assign mem_wdata = pop ? head[7:0] : last_wdata;
    assign busy      = !fifo_empty || mem_we;
    assign rd_data   = mem_rdata;

    // FIFO storage; no reset so it maps onto plain registers or a small RAM.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= {in_y, in_x, px_data};
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky drop flag, read valid pipeline and held RAM address/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow   <= 1'b0;
            rd_valid   <= 1'b0;
            last_addr  <= '0;
            last_wdata <= '0;
        end else begin
            if (paint && (count == FULL_CNT))
                overflow <= 1'b1;
            rd_valid   <= rd_ready;
            last_addr  <= mem_addr;
            last_wdata <= mem_wdata;
        end
    end

`ifdef FB_STARVE_GUARD_EN
    // Counts cycles a queued write is blocked by the scan; any write clears it.
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (pop)
            starve_cnt <= '0;
        else if (!fifo_empty && rd_en)
            starve_cnt <= starve_cnt + SW'(1);
    end
`endif

endmodule

// File: tb/tb_fb_paint_responder.sv
// Directed, table-driven bench for fb_paint_responder (default parameters).
module tb_fb_paint_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        paint;
    logic [5:0]  in_x;
    logic [5:0]  in_y;
    logic [7:0]  px_data;
    logic        busy;
    logic        overflow;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    always #5 clk = ~clk;

    fb_paint_responder #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst), .paint(paint), .in_x(in_x), .in_y(in_y),
        .px_data(px_data), .busy(busy), .overflow(overflow), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        rst;
        logic        paint;
        logic [5:0]  x;
        logic [5:0]  y;
        logic [7:0]  d;
        logic        rd;
        logic [11:0] ra;
        logic        we;
        logic [11:0] addr;
        logic [7:0]  wd;
        logic        rdy;
        logic        vld;
        logic        busy;
        logic        ovf;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic vec_t mk(input logic r, input logic p, input logic [5:0] x,
                                input logic [5:0] y, input logic [7:0] d,
                                input logic rd, input logic [11:0] ra,
                                input logic we, input logic [11:0] addr,
                                input logic [7:0] wd, input logic rdy,
                                input logic vld, input logic bsy, input logic ovf);
        vec_t v;
        v.rst = r; v.paint = p; v.x = x; v.y = y; v.d = d; v.rd = rd; v.ra = ra;
        v.we = we; v.addr = addr; v.wd = wd; v.rdy = rdy; v.vld = vld;
        v.busy = bsy; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; paint = 1'b0; in_x = '0; in_y = '0; px_data = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic apply(input vec_t v, input int row);
        logic [7:0] mr;
        @(negedge clk);
        rst = v.rst; paint = v.paint; in_x = v.x; in_y = v.y; px_data = v.d;
        rd_en = v.rd; rd_addr = v.ra;
        mr = 8'($urandom);
        mem_rdata = mr;
        #1;
        chk("mem_we",    row, 32'(mem_we),    32'(v.we));
        chk("mem_addr",  row, 32'(mem_addr),  32'(v.addr));
        chk("mem_wdata", row, 32'(mem_wdata), 32'(v.wd));
        chk("rd_ready",  row, 32'(rd_ready),  32'(v.rdy));
        chk("rd_valid",  row, 32'(rd_valid),  32'(v.vld));
        chk("busy",      row, 32'(busy),      32'(v.busy));
        chk("overflow",  row, 32'(overflow),  32'(v.ovf));
        chk("rd_data",   row, 32'(rd_data),   32'(mr));
    endtask

    initial begin
        drive_idle();
        mem_rdata = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        //               rst p  x  y  d      rd ra       we addr     wd     rdy vld bsy ovf
        // reset state and single write
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 5, 3, 8'hFF, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h0C5, 8'hFF, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h0C5, 8'hFF, 0, 0, 0, 0));
        // read priority over a pending write
        vecs.push_back(mk(0, 1, 0, 0, 8'h00, 1, 12'h123, 0, 12'h123, 8'hFF, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 12'h456, 0, 12'h456, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 1, 12'h789, 0, 12'h789, 8'hFF, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h000, 8'h00, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 0, 0));
        // five paints under reads: fifth dropped, four retire in order
        vecs.push_back(mk(0, 1, 1, 1, 8'hA1, 1, 12'h001, 0, 12'h001, 8'h00, 1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 1, 8'hA2, 1, 12'h002, 0, 12'h002, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 3, 1, 8'hA3, 1, 12'h003, 0, 12'h003, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 4, 1, 8'hA4, 1, 12'h004, 0, 12'h004, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 5, 1, 8'hA5, 1, 12'h005, 0, 12'h005, 8'h00, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h041, 8'hA1, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h042, 8'hA2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h043, 8'hA3, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h044, 8'hA4, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h044, 8'hA4, 0, 0, 0, 1));
        // simultaneous push and pop at count 2
        vecs.push_back(mk(0, 1, 0, 2, 8'hB0, 1, 12'hFFF, 0, 12'hFFF, 8'hA4, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 2, 8'hB1, 1, 12'hFFE, 0, 12'hFFE, 8'hA4, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 2, 2, 8'hB2, 0, 12'h000, 1, 12'h080, 8'hB0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h081, 8'hB1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h082, 8'hB2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h082, 8'hB2, 0, 0, 0, 1));
        // paint on a full FIFO in the same cycle as a pop is still dropped
        vecs.push_back(mk(0, 1, 0, 4, 8'hC0, 1, 12'h3AB, 0, 12'h3AB, 8'hB2, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 1, 4, 8'hC1, 1, 12'h3AB, 0, 12'h3AB, 8'hB2, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 2, 4, 8'hC2, 1, 12'h3AB, 0, 12'h3AB, 8'hB2, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 3, 4, 8'hC3, 1, 12'h3AB, 0, 12'h3AB, 8'hB2, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 9, 4, 8'hC9, 0, 12'h000, 1, 12'h100, 8'hC0, 0, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h101, 8'hC1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h102, 8'hC2, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 1, 12'h103, 8'hC3, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h103, 8'hC3, 0, 0, 0, 1));
        // reset with three entries queued and a read in flight
        vecs.push_back(mk(0, 1, 7, 7, 8'hD0, 1, 12'h200, 0, 12'h200, 8'hC3, 1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8, 7, 8'hD1, 1, 12'h201, 0, 12'h201, 8'hC3, 1, 1, 1, 1));
        vecs.push_back(mk(0, 1, 9, 7, 8'hD2, 1, 12'h202, 0, 12'h202, 8'hC3, 1, 1, 1, 1));
        vecs.push_back(mk(1, 0, 0, 0, 8'h00, 1, 12'h203, 0, 12'h203, 8'hC3, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 8'h00, 0, 12'h000, 0, 12'h000, 8'h00, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], i);

`ifdef FB_STARVE_GUARD_EN
        // Continuous scan with one queued paint: the ninth cycle is a forced write.
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; paint = 1'b1; in_x = 6'd1; in_y = 6'd1; px_data = 8'h5A;
        rd_en = 1'b1; rd_addr = 12'h03C;
        #1;
        chk("guard_paint_rdy", 0, 32'(rd_ready), 32'd1);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            paint = 1'b0;
            #1;
            chk("guard_blocked_rdy", c, 32'(rd_ready), 32'd1);
            chk("guard_blocked_we",  c, 32'(mem_we),   32'd0);
        end
        @(negedge clk);
        #1;
        chk("guard_force_rdy",   9, 32'(rd_ready),  32'd0);
        chk("guard_force_we",    9, 32'(mem_we),    32'd1);
        chk("guard_force_addr",  9, 32'(mem_addr),  32'h041);
        chk("guard_force_wdata", 9, 32'(mem_wdata), 32'h5A);
        @(negedge clk);
        #1;
        chk("guard_after_rdy",  10, 32'(rd_ready), 32'd1);
        chk("guard_after_we",   10, 32'(mem_we),   32'd0);
        chk("guard_after_busy", 10, 32'(busy),     32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
